// File: rtl/stopwatch_pkg.sv
// Shared types and default timing constants for the stopwatch control unit
// and the BCD digit-counter chain it drives.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } sw_state_t;

  localparam int unsigned SW_CLK_DIV         = 260000;
  localparam int unsigned SW_DEBOUNCE_CYCLES = 65536;

  function automatic logic sw_is_running(input sw_state_t s);
    return (s == RUN) || (s == LAP);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and counter-chain control outputs of the stopwatch controller.
// master = controller side, slave = board/counter-chain side.
interface stopwatch_ctrl_if;
  import stopwatch_pkg::*;

  logic      btn_ss;
  logic      btn_lr;
  logic      tick_100hz;
  logic      count_clr;
  logic      display_hold;
  logic      running;
  sw_state_t state_o;

  modport master (
    input  btn_ss, btn_lr,
    output tick_100hz, count_clr, display_hold, running, state_o
  );

  modport slave (
    output btn_ss, btn_lr,
    input  tick_100hz, count_clr, display_hold, running, state_o
  );
endinterface

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// One button input path: 2-FF synchroniser, debounce counter, rising-edge press pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             s1_q, s2_q;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter only runs while the synced level differs from the accepted one,
  // so any bounce back to the accepted level restarts it.
  always_comb begin
    stable_d = stable_q;
    press_d  = 1'b0;
    cnt_d    = '0;
    if (s2_q != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = s2_q;
        press_d  = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= btn_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press_o = press_q;
endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced start/stop and lap/clear buttons, run/lap/pause/idle
// FSM, and the 0.01 s tick prescaler feeding the digit-counter chain.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_DIV         = SW_CLK_DIV,
  parameter int unsigned DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES
) (
  input logic               clk,
  input logic               reset,
  stopwatch_ctrl_if.master  sw
);
  localparam int unsigned PRESC_W = $clog2(CLK_DIV);

  logic               press_ss, press_lr;
  sw_state_t          state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               clr_q, clr_d;
  logic               run_w, wrap_w;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
    .clk(clk), .reset(reset), .btn_i(sw.btn_ss), .press_o(press_ss)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lr (
    .clk(clk), .reset(reset), .btn_i(sw.btn_lr), .press_o(press_lr)
  );

  assign run_w  = sw_is_running(state_q);
  assign wrap_w = (presc_q == PRESC_W'(CLK_DIV - 1));

  // Start/stop is tested first so it wins a same-cycle collision with lap/clear.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    presc_d = presc_q;
    if (run_w) presc_d = wrap_w ? '0 : presc_q + 1'b1;
    case (state_q)
      IDLE:  if (press_ss) state_d = RUN;
      RUN:   if (press_ss) state_d = PAUSE;
             else if (press_lr) state_d = LAP;
      LAP:   if (press_ss) state_d = PAUSE;
             else if (press_lr) state_d = RUN;
      PAUSE: if (press_ss) state_d = RUN;
             else if (press_lr) begin
               state_d = IDLE;
               clr_d   = 1'b1;
               presc_d = '0;
             end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      clr_q   <= clr_d;
    end
  end

  assign sw.tick_100hz   = run_w & wrap_w;
  assign sw.count_clr    = clr_q;
  assign sw.display_hold = (state_q == LAP);
  assign sw.running      = run_w;
  assign sw.state_o      = state_q;
endmodule
